run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//  Synthesizable run-control monitor on the CPU memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb).
//  Counts run cycles, captures writes to NUM_CH watched MMIO addresses, ends the run on a write to channel 0 (DONE),
//  and flags a timeout. Sits beside riscv_top; replaces bench-side DONE/timeout logic so FPGA and sim share it.
// PARAMETERS
//  ADDR_W     32          bus address width
//  DATA_W     32          bus data width (multiple of 8); strobe width SW = DATA_W/8
//  NUM_CH     4           watched channels (>=1); channel 0 = DONE
//  CH_ADDRS   {..,32'h10} NUM_CH*ADDR_W packed; channel i at bits [i*ADDR_W +: ADDR_W]; must be word-aligned
//  CNT_W      32          cycle counter width
//  TIMEOUT    2000000     run cycles before timeout; 0 disables timeout
//  PASS_VAL   32'h1       DONE write value meaning pass
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            async active-low reset
//  start      in   1            pulse: IDLE->RUN
//  clear      in   1            pulse: any state ->IDLE, clears counters/captures
//  mem_valid  in   1            bus request valid
//  mem_ready  in   1            bus request accepted
//  mem_addr   in   ADDR_W       bus address
//  mem_wdata  in   DATA_W       bus write data
//  mem_wstrb  in   SW           byte strobes; nonzero = write
//  running    out  1            state==RUN
//  done       out  1            state==DONE (sticky)
//  timeout    out  1            state==TIMEOUT (sticky)
//  pass       out  1            done && done_data==PASS_VAL
//  cycle_count out CNT_W        cycles spent in RUN, frozen on exit
//  done_data  out  DATA_W       = channel 0 capture
//  ch_hit     out  NUM_CH       per-channel sticky "written" flag
//  ch_data    out  NUM_CH*DATA_W per-channel captured data, channel i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; ch_data 0.
//  FSM IDLE->RUN on start; RUN->DONE on ch0 write; RUN->TIMEOUT when cycle_count==TIMEOUT-1 and no ch0 write;
//   DONE/TIMEOUT hold until clear. clear has priority over all other inputs (incl. start same cycle).
//  Write event: mem_valid & mem_ready & |mem_wstrb, sampled at posedge. Match on addr[ADDR_W-1:2] (word compare).
//  Captures only in RUN: ch_data[i] byte b <= wdata byte b where wstrb[b]; others keep value; ch_hit[i]<=1.
//   Visible the cycle after the write edge. Duplicate CH_ADDRS: lowest index only captures.
//  cycle_count: 0 in IDLE; +1 each RUN cycle incl. the exit cycle; saturates at all-ones; frozen in DONE/TIMEOUT.
//  ch0 write and timeout condition same cycle -> DONE wins, data captured, timeout stays 0.
//  Writes in IDLE/DONE/TIMEOUT ignored; reads (wstrb==0) and unhandshaken valid (mem_ready=0) ignored.
//  start while RUN/DONE/TIMEOUT ignored. clear -> IDLE next cycle, counters/captures/hits zeroed.
//  rst_n mid-run: immediate return to reset values, no partial capture.
// STRUCTURE
//  Package run_monitor_pkg: state enum {IDLE,RUN,DONE,TIMEOUT} (2-bit), default DONE addr 32'h10, PASS_VAL.
//  One sub-module run_monitor_ch (per-channel address match + byte-merge capture + hit flag), generated NUM_CH times;
//   top holds FSM, counter, priority select for duplicate addresses.
// TESTING
//  start, 10 idle cycles, sw 0xDEADBEEF @0x10 -> done=1, pass=0, done_data=DEADBEEF, cycle_count=11, running=0.
//  sw 0x1 @0x10 -> pass=1; further sw @0x10 of 0x2 -> done_data stays 0x1.
//  TIMEOUT=50, no writes -> timeout=1 after 50 RUN cycles, cycle_count=50, done=0; ch0 write on cycle 50 -> done=1, timeout=0.
//  sb 0xAB strobe 4'b0100 @ch1 addr after sw 0x11223344 -> ch_data[1]=0x11AB3344, ch_hit=4'b0010.
//  Write with mem_ready=0 or wstrb=0 to 0x10 -> no state change; write in IDLE -> ch_hit stays 0.
//  rst_n low mid-run and clear asserted with start same cycle -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the run-control monitor: FSM state encoding,
// default watched addresses (channel 0 is DONE) and the default pass value.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0]  DONE_ADDR    = 32'h0000_0010;
    localparam logic [31:0]  PASS_VAL_DEF = 32'h0000_0001;
    localparam logic [127:0] DEF_CH_ADDRS = {32'h0000_001C, 32'h0000_0018,
                                             32'h0000_0014, DONE_ADDR};

endpackage

// File: rtl/run_monitor_ch.sv
// One watched MMIO channel: word-address match, byte-strobed capture and a
// sticky hit flag. The top decides which matching channel actually captures.
module run_monitor_ch
    import run_monitor_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter logic [ADDR_W-1:0] CH_ADDR = DONE_ADDR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic [ADDR_W-3:0]   addr_word_i,
    output logic                match_o,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                hit_o,
    output logic [DATA_W-1:0]   data_o
);

    localparam int unsigned SW = DATA_W / 8;

    logic              hit_q, hit_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign match_o = (addr_word_i == CH_ADDR[ADDR_W-1:2]);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missed branch would infer a latch.
        hit_d  = hit_q;
        data_d = data_q;
        if (clr_i) begin
            hit_d  = 1'b0;
            data_d = '0;
        end else if (we_i) begin
            hit_d = 1'b1;
            for (int b = 0; b < SW; b++) begin
                if (wstrb_i[b]) data_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= 1'b0;
            data_q <= '0;
        end else begin
            hit_q  <= hit_d;
            data_q <= data_d;
        end
    end

    assign hit_o  = hit_q;
    assign data_o = data_q;

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor on the CPU memory bus: counts run cycles, captures writes
// to watched MMIO channels, ends the run on a DONE write or flags a timeout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned              ADDR_W   = 32,
    parameter int unsigned              DATA_W   = 32,
    parameter int unsigned              NUM_CH   = 4,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDRS = DEF_CH_ADDRS,
    parameter int unsigned              CNT_W    = 32,
    parameter int unsigned              TIMEOUT  = 2000000,
    parameter logic [DATA_W-1:0]        PASS_VAL = PASS_VAL_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       mem_valid,
    input  logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W/8-1:0]        mem_wstrb,
    output logic                       running,
    output logic                       done,
    output logic                       timeout,
    output logic                       pass,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [DATA_W-1:0]          done_data,
    output logic [NUM_CH-1:0]          ch_hit,
    output logic [NUM_CH*DATA_W-1:0]   ch_data
);

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              running_q, done_q, timeout_q;
    logic              wr_ev, in_run, found;
    logic [NUM_CH-1:0] ch_match, ch_we;
    logic              unused_addr_lsb;

    assign wr_ev           = mem_valid & mem_ready & (|mem_wstrb);
    assign in_run          = (state_q == ST_RUN);
    assign cnt_inc         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign unused_addr_lsb = ^mem_addr[1:0];

    // Duplicate addresses: only the lowest-indexed matching channel captures.
    always_comb begin
        ch_we = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_match[i] && !found) begin
                ch_we[i] = wr_ev & in_run;
                found    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        run_monitor_ch #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .CH_ADDR (CH_ADDRS[g*ADDR_W +: ADDR_W])
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (clear),
            .addr_word_i (mem_addr[ADDR_W-1:2]),
            .match_o     (ch_match[g]),
            .we_i        (ch_we[g]),
            .wdata_i     (mem_wdata),
            .wstrb_i     (mem_wstrb),
            .hit_o       (ch_hit[g]),
            .data_o      (ch_data[g*DATA_W +: DATA_W])
        );
    end

    // A DONE write on the timeout cycle takes the DONE branch first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_inc;
                    if (ch_we[0]) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (TO_EN && cnt_q == TO_LAST) begin
                        state_q   <= ST_TIMEOUT;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;
    assign done_data   = ch_data[DATA_W-1:0];
    assign pass        = done_q && (done_data == PASS_VAL);

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a default instance with a short timeout and
// a small instance with duplicate addresses, 4-bit counter and timeout off.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        rst_n, start, clear;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic         a_running, a_done, a_timeout, a_pass;
    logic [31:0]  a_cycle_count, a_done_data;
    logic [3:0]   a_ch_hit;
    logic [127:0] a_ch_data;

    logic         b_running, b_done, b_timeout, b_pass;
    logic [3:0]   b_cycle_count;
    logic [31:0]  b_done_data;
    logic [2:0]   b_ch_hit;
    logic [95:0]  b_ch_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_monitor #(.TIMEOUT(50)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .running(a_running), .done(a_done), .timeout(a_timeout), .pass(a_pass),
        .cycle_count(a_cycle_count), .done_data(a_done_data),
        .ch_hit(a_ch_hit), .ch_data(a_ch_data)
    );

    run_monitor #(
        .NUM_CH(3), .CH_ADDRS({32'h14, 32'h14, 32'h10}), .CNT_W(4), .TIMEOUT(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .running(b_running), .done(b_done), .timeout(b_timeout), .pass(b_pass),
        .cycle_count(b_cycle_count), .done_data(b_done_data),
        .ch_hit(b_ch_hit), .ch_data(b_ch_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks begin and end at a falling edge; each consumes whole cycles.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic rdy);
        mem_valid = 1'b1; mem_ready = rdy; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        @(negedge clk);
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, ".running"}, a_running, 1'b0);
        check({tag, ".done"}, a_done, 1'b0);
        check({tag, ".timeout"}, a_timeout, 1'b0);
        check({tag, ".pass"}, a_pass, 1'b0);
        check({tag, ".cycles"}, a_cycle_count, 32'd0);
        check({tag, ".hit"}, a_ch_hit, 4'b0000);
        check({tag, ".data"}, a_ch_data, 128'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        idle(2);
        check_a_cleared("reset");
        check("reset.b_hit", b_ch_hit, 3'b000);
        rst_n = 1'b1;
        idle(1);

        // start, 10 idle cycles, DONE write of a non-pass value
        pulse_start();
        check("run.running", a_running, 1'b1);
        idle(10);
        check("run.cycles10", a_cycle_count, 32'd10);
        bus_wr(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        check("t1.done", a_done, 1'b1);
        check("t1.pass", a_pass, 1'b0);
        check("t1.done_data", a_done_data, 32'hDEADBEEF);
        check("t1.cycles", a_cycle_count, 32'd11);
        check("t1.running", a_running, 1'b0);
        check("t1.timeout", a_timeout, 1'b0);
        check("t1.b_cycles", b_cycle_count, 4'd11);
        bus_wr(32'h10, 32'h2, 4'hF, 1'b1);
        check("t1.frozen_data", a_done_data, 32'hDEADBEEF);
        check("t1.frozen_cycles", a_cycle_count, 32'd11);

        // clear, ignored IDLE write, byte merge, rejected writes, pass
        pulse_clear();
        check_a_cleared("clear");
        bus_wr(32'h10, 32'h1, 4'hF, 1'b1);
        check("idle_wr.hit", a_ch_hit, 4'b0000);
        check("idle_wr.done", a_done, 1'b0);
        pulse_start();
        bus_wr(32'h14, 32'h11223344, 4'hF, 1'b1);
        bus_wr(32'h14, 32'hFFABFFFF, 4'b0100, 1'b1);
        check("merge.ch1", a_ch_data[63:32], 32'h11AB3344);
        check("merge.hit", a_ch_hit, 4'b0010);
        check("dup.b_hit", b_ch_hit, 3'b010);
        check("dup.b_ch1", b_ch_data[63:32], 32'h11AB3344);
        check("dup.b_ch2", b_ch_data[95:64], 32'h0);
        bus_wr(32'h10, 32'h1, 4'hF, 1'b0);
        check("noready.running", a_running, 1'b1);
        check("noready.hit", a_ch_hit, 4'b0010);
        bus_wr(32'h10, 32'h1, 4'h0, 1'b1);
        check("read.running", a_running, 1'b1);
        pulse_start();
        check("restart.cycles", a_cycle_count, 32'd5);
        bus_wr(32'h12, 32'h1, 4'hF, 1'b1);
        check("t2.pass", a_pass, 1'b1);
        check("t2.done_data", a_done_data, 32'h1);
        check("t2.cycles", a_cycle_count, 32'd6);
        check("t2.hit", a_ch_hit, 4'b0011);
        check("t2.b_hit", b_ch_hit, 3'b011);
        bus_wr(32'h10, 32'h2, 4'hF, 1'b1);
        check("t2.sticky_data", a_done_data, 32'h1);
        check("t2.sticky_pass", a_pass, 1'b1);

        // clear and start together: clear wins
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check_a_cleared("clr_start");
        idle(2);
        check("clr_start.still_idle", a_running, 1'b0);

        // timeout after 50 RUN cycles; instance b saturates and keeps running
        pulse_start();
        idle(49);
        check("to.before", a_timeout, 1'b0);
        check("to.cycles49", a_cycle_count, 32'd49);
        idle(1);
        check("to.timeout", a_timeout, 1'b1);
        check("to.cycles", a_cycle_count, 32'd50);
        check("to.done", a_done, 1'b0);
        check("to.running", a_running, 1'b0);
        check("to.b_running", b_running, 1'b1);
        check("to.b_sat", b_cycle_count, 4'hF);
        check("to.b_timeout", b_timeout, 1'b0);
        bus_wr(32'h10, 32'h1, 4'hF, 1'b1);
        check("to.late_done", a_done, 1'b0);
        check("to.frozen", a_cycle_count, 32'd50);

        // DONE write on the timeout cycle: DONE wins
        pulse_clear();
        pulse_start();
        idle(49);
        bus_wr(32'h10, 32'h1, 4'hF, 1'b1);
        check("race.done", a_done, 1'b1);
        check("race.timeout", a_timeout, 1'b0);
        check("race.cycles", a_cycle_count, 32'd50);
        check("race.data", a_done_data, 32'h1);

        // async reset mid-run with a write pending
        pulse_clear();
        pulse_start();
        idle(3);
        bus_wr(32'h14, 32'h55, 4'hF, 1'b1);
        check("rst.pre_hit", a_ch_hit, 4'b0010);
        mem_valid = 1'b1; mem_ready = 1'b1; mem_addr = 32'h18;
        mem_wdata = 32'h77; mem_wstrb = 4'hF;
        rst_n = 1'b0;
        #1;
        check_a_cleared("rst.async");
        @(negedge clk);
        mem_valid = 1'b0; mem_ready = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        rst_n = 1'b1;
        idle(1);
        check_a_cleared("rst.after");
        check("rst.b_hit", b_ch_hit, 3'b000);
        check("rst.b_running", b_running, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
